// File: rtl/cgp_tt_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector into a candidate circuit and counts mismatched output bits.
// Optional feature CGP_TT_ERRMASK_EN adds err_mask, a sticky per-output mismatch flag.
module cgp_tt_sweeper #(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 7,
  parameter int DUT_LAT = 0,
  parameter int CW      = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  dut_pi,
  input  logic [N_OUT-1:0] dut_po,
  output logic [N_IN-1:0]  gold_addr,
  input  logic [N_OUT-1:0] gold_data,
  output logic [CW-1:0]    err_cnt,
  output logic             perfect,
  output logic             result_valid
`ifdef CGP_TT_ERRMASK_EN
  ,
  output logic [N_OUT-1:0] err_mask
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for start; last result held
  // S_SWEEP | driving vector dut_pi, one per cycle
  // S_DRAIN | last vector driven, waiting for the DUT pipeline to empty
  // S_DONE  | one-cycle completion, done pulses
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  localparam int PW = $clog2(N_OUT + 1);
  localparam int SW = ((CW > PW) ? CW : PW) + 1;
  localparam logic [N_IN-1:0] VEC_LAST   = '1;
  localparam logic [2:0]      DRAIN_INIT = (DUT_LAT > 0) ? 3'(DUT_LAT - 1) : 3'd0;
  localparam logic [SW-1:0]   ERR_MAX    = SW'((64'd1 << CW) - 64'd1);

  state_t           state;
  logic [2:0]       drain_cnt;
  logic             cmp_vld;
  logic [N_IN-1:0]  cmp_vec;
  logic [N_OUT-1:0] diff;
  logic [PW-1:0]    pop;
  logic [SW-1:0]    err_sum;
  logic [CW-1:0]    err_nxt;
  logic             in_run;
  logic             flush;
  logic             accept;

  assign in_run    = (state == S_SWEEP) || (state == S_DRAIN);
  assign flush     = in_run && abort;
  assign accept    = (state == S_IDLE) && start && !abort;
  assign gold_addr = cmp_vec;

  // Compare pipe: tags each driven vector so the golden lookup lines up with the DUT latency.
  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign cmp_vld = (state == S_SWEEP);
      assign cmp_vec = dut_pi;
    end else begin : g_lat
      logic [DUT_LAT-1:0] dl_vld;
      logic [N_IN-1:0]    dl_vec [DUT_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dl_vld <= '0;
          for (int i = 0; i < DUT_LAT; i++) dl_vec[i] <= '0;
        end else if (flush) begin
          dl_vld <= '0;
        end else begin
          dl_vld[0] <= (state == S_SWEEP);
          dl_vec[0] <= dut_pi;
          for (int i = 1; i < DUT_LAT; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_vec[i] <= dl_vec[i-1];
          end
        end
      end

      assign cmp_vld = dl_vld[DUT_LAT-1];
      assign cmp_vec = dl_vec[DUT_LAT-1];
    end
  endgenerate

  always_comb begin
    diff = dut_po ^ gold_data;
    pop  = '0;
    for (int j = 0; j < N_OUT; j++) pop = pop + PW'(diff[j]);
    err_sum = SW'(err_cnt) + SW'(pop);
    err_nxt = err_cnt;
    if (cmp_vld) err_nxt = (err_sum > ERR_MAX) ? ERR_MAX[CW-1:0] : err_sum[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      dut_pi       <= '0;
      err_cnt      <= '0;
      perfect      <= 1'b0;
      result_valid <= 1'b0;
      drain_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state        <= S_SWEEP;
            busy         <= 1'b1;
            dut_pi       <= '0;
            err_cnt      <= '0;
            perfect      <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            err_cnt <= err_nxt;
            if (dut_pi == VEC_LAST) begin
              if (DUT_LAT > 0) begin
                state     <= S_DRAIN;
                drain_cnt <= DRAIN_INIT;
              end else begin
                state        <= S_DONE;
                busy         <= 1'b0;
                done         <= 1'b1;
                result_valid <= 1'b1;
                perfect      <= (err_nxt == '0);
              end
            end else begin
              dut_pi <= dut_pi + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            err_cnt <= err_nxt;
            if (drain_cnt == 3'd0) begin
              state        <= S_DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              result_valid <= 1'b1;
              perfect      <= (err_nxt == '0);
            end else begin
              drain_cnt <= drain_cnt - 3'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CGP_TT_ERRMASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_mask <= '0;
    end else if (accept) begin
      err_mask <= '0;
    end else if (in_run && !abort && cmp_vld) begin
      err_mask <= err_mask | diff;
    end
  end
`endif

endmodule

// File: tb/tb_cgp_tt_sweeper.sv
// Bench for cgp_tt_sweeper: instance a (DUT_LAT=0, CW=7) and instance b (DUT_LAT=2, CW=6).
// Expected results are pushed to a scoreboard at start and popped when done pulses.
module tb_cgp_tt_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0;

  logic       busy_a, done_a, perf_a, rv_a;
  logic [3:0] pi_a, ga_a;
  logic [6:0] po_a, gd_a, err_a;
  logic       busy_b, done_b, perf_b, rv_b;
  logic [3:0] pi_b, ga_b;
  logic [6:0] po_b, gd_b;
  logic [5:0] err_b;
`ifdef CGP_TT_ERRMASK_EN
  logic [6:0] mask_a, mask_b;
`endif

  logic [6:0] flt_a [16];
  logic [6:0] flt_b [16];
  logic [6:0] r1_b = '0, r2_b = '0;

  function automatic logic [6:0] gold(input logic [3:0] a);
    return {a[3] ^ a[1], a[2] & a[0], ~a[1], a};
  endfunction

  assign po_a = gold(pi_a) ^ flt_a[pi_a];
  assign gd_a = gold(ga_a);
  always @(posedge clk) begin
    r1_b <= gold(pi_b) ^ flt_b[pi_b];
    r2_b <= r1_b;
  end
  assign po_b = r2_b;
  assign gd_b = gold(ga_b);

  cgp_tt_sweeper #(.N_IN(4), .N_OUT(7), .DUT_LAT(0), .CW(7)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .dut_pi(pi_a), .dut_po(po_a),
    .gold_addr(ga_a), .gold_data(gd_a), .err_cnt(err_a),
    .perfect(perf_a), .result_valid(rv_a)
`ifdef CGP_TT_ERRMASK_EN
    , .err_mask(mask_a)
`endif
  );

  cgp_tt_sweeper #(.N_IN(4), .N_OUT(7), .DUT_LAT(2), .CW(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .dut_pi(pi_b), .dut_po(po_b),
    .gold_addr(ga_b), .gold_data(gd_b), .err_cnt(err_b),
    .perfect(perf_b), .result_valid(rv_b)
`ifdef CGP_TT_ERRMASK_EN
    , .err_mask(mask_b)
`endif
  );

  typedef struct packed {
    logic [6:0] err;
    logic       perf;
    logic [6:0] mask;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic sel = 1'b0;
  logic [6:0] last_err_a = '0;
  logic       last_perf_a = 1'b0;

  logic       o_busy, o_done, o_perf, o_rv;
  logic [3:0] o_pi;
  logic [6:0] o_err;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_perf = sel ? perf_b : perf_a;
  assign o_rv   = sel ? rv_b : rv_a;
  assign o_pi   = sel ? pi_b : pi_a;
  assign o_err  = sel ? {1'b0, err_b} : err_a;
`ifdef CGP_TT_ERRMASK_EN
  logic [6:0] o_mask;
  assign o_mask = sel ? mask_b : mask_a;
`endif

  task automatic drive_start(input logic s, input logic v);
    if (s) start_b = v;
    else   start_a = v;
  endtask

  task automatic sweep(input logic s, input int lat, input logic poke);
    exp_t e, got;
    int tot, sat;
    logic [6:0] m;
    sel = s;
    tot = 0;
    m = '0;
    for (int v = 0; v < 16; v++) begin
      tot += s ? $countones(flt_b[v]) : $countones(flt_a[v]);
      m |= s ? flt_b[v] : flt_a[v];
    end
    sat = s ? 63 : 127;
    if (tot > sat) tot = sat;
    e.err  = 7'(tot);
    e.perf = (tot == 0);
    e.mask = m;
    sb.push_back(e);
    @(posedge clk); #1;
    drive_start(s, 1'b1);
    @(posedge clk); #1;
    drive_start(s, 1'b0);
    for (int cyc = 0; cyc <= 18 + lat; cyc++) begin
      checks++;
      if (o_busy !== (cyc < 16 + lat)) begin
        errors++; $display("FAIL busy cyc=%0d: got %b expected %b", cyc, o_busy, (cyc < 16 + lat));
      end
      checks++;
      if (o_done !== (cyc == 16 + lat)) begin
        errors++; $display("FAIL done cyc=%0d: got %b expected %b", cyc, o_done, (cyc == 16 + lat));
      end
      checks++;
      if (o_pi !== 4'((cyc < 16) ? cyc : 15)) begin
        errors++; $display("FAIL dut_pi cyc=%0d: got %0d expected %0d", cyc, o_pi, (cyc < 16) ? cyc : 15);
      end
      if (!s) begin
        checks++;
        if (ga_a !== pi_a) begin
          errors++; $display("FAIL gold_addr cyc=%0d: got %0d expected %0d", cyc, ga_a, pi_a);
        end
      end
      if (cyc == 0) begin
        checks++;
        if (o_err !== 7'd0) begin
          errors++; $display("FAIL err_clear: got %0d expected 0", o_err);
        end
      end
      if (cyc < 16 + lat) begin
        checks++;
        if (o_rv !== 1'b0 || o_perf !== 1'b0) begin
          errors++; $display("FAIL rv_busy cyc=%0d: got rv=%b perfect=%b expected 0 0", cyc, o_rv, o_perf);
        end
      end else begin
        checks++;
        if (o_rv !== 1'b1) begin
          errors++; $display("FAIL result_valid cyc=%0d: got %b expected 1", cyc, o_rv);
        end
      end
      if (o_done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL sb_extra_done cyc=%0d: got done expected none", cyc);
        end else begin
          got = sb.pop_front();
          checks++;
          if (o_err !== got.err) begin
            errors++; $display("FAIL err_cnt: got %0d expected %0d", o_err, got.err);
          end
          checks++;
          if (o_perf !== got.perf) begin
            errors++; $display("FAIL perfect: got %b expected %b", o_perf, got.perf);
          end
`ifdef CGP_TT_ERRMASK_EN
          checks++;
          if (o_mask !== got.mask) begin
            errors++; $display("FAIL err_mask: got %b expected %b", o_mask, got.mask);
          end
`endif
        end
      end
      if (poke) drive_start(s, (cyc == 5) || (cyc == 16 + lat));
      @(posedge clk); #1;
    end
    drive_start(s, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    if (!s) begin
      last_err_a  = e.err;
      last_perf_a = e.perf;
    end
  endtask

  task automatic check_a_reset(input string tag);
    checks++;
    if ({busy_a, done_a, pi_a, ga_a, err_a, perf_a, rv_a} !== '0) begin
      errors++;
      $display("FAIL %s_a: got busy=%b done=%b pi=%0d ga=%0d err=%0d perf=%b rv=%b expected all 0",
               tag, busy_a, done_a, pi_a, ga_a, err_a, perf_a, rv_a);
    end
    checks++;
    if ({busy_b, done_b, pi_b, ga_b, err_b, perf_b, rv_b} !== '0) begin
      errors++;
      $display("FAIL %s_b: got busy=%b done=%b pi=%0d ga=%0d err=%0d perf=%b rv=%b expected all 0",
               tag, busy_b, done_b, pi_b, ga_b, err_b, perf_b, rv_b);
    end
`ifdef CGP_TT_ERRMASK_EN
    checks++;
    if ({mask_a, mask_b} !== '0) begin
      errors++; $display("FAIL %s_mask: got %b %b expected 0 0", tag, mask_a, mask_b);
    end
`endif
  endtask

  task automatic set_faults(input logic s, input logic [6:0] v);
    for (int i = 0; i < 16; i++) begin
      if (s) flt_b[i] = v;
      else   flt_a[i] = v;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_a_reset("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_perfect();
    set_faults(1'b0, 7'h00);
    sweep(1'b0, 0, 1'b0);
  endtask

  task automatic test_po6_inverted();
    set_faults(1'b0, 7'h40);
    sweep(1'b0, 0, 1'b0);
  endtask

  task automatic test_all_inverted();
    set_faults(1'b0, 7'h7f);
    sweep(1'b0, 0, 1'b0);
  endtask

  task automatic test_latency2();
    set_faults(1'b1, 7'h00);
    sweep(1'b1, 2, 1'b0);
  endtask

  task automatic test_saturation();
    set_faults(1'b1, 7'h7f);
    sweep(1'b1, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) flt_a[i] = 7'($urandom_range(0, 127) & $urandom_range(0, 127));
    sweep(1'b0, 0, 1'b1);
    for (int i = 0; i < 16; i++) flt_b[i] = 7'($urandom_range(0, 127) & $urandom_range(0, 127));
    sweep(1'b1, 2, 1'b1);
  endtask

  task automatic test_abort();
    sel = 1'b0;
    @(posedge clk); #1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    checks++;
    if (rv_a !== 1'b1 || err_a !== last_err_a || perf_a !== last_perf_a || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got rv=%b err=%0d perf=%b busy=%b expected 1 %0d %b 0",
               rv_a, err_a, perf_a, busy_a, last_err_a, last_perf_a);
    end
    flt_a[3] = 7'h05;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b1 || pi_a !== 4'd5) begin
      errors++; $display("FAIL abort_pre: got busy=%b pi=%0d expected 1 5", busy_a, pi_a);
    end
    abort_a = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || rv_a !== 1'b0 || perf_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_sweep: got busy=%b rv=%b perf=%b done=%b expected 0 0 0 0", busy_a, rv_a, perf_a, done_a);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++; $display("FAIL abort_quiet i=%0d: got done=%b busy=%b expected 0 0", i, done_a, busy_a);
      end
      @(posedge clk); #1;
    end
    sweep(1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    set_faults(1'b0, 7'h11);
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_a_reset("reset_mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++; $display("FAIL reset_hold i=%0d: got done=%b busy=%b expected 0 0", i, done_a, busy_a);
      end
    end
    rst_n = 1'b1;
    sweep(1'b0, 0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      flt_a[i] = '0;
      flt_b[i] = '0;
    end
    test_reset();
    test_perfect();
    test_po6_inverted();
    test_all_inverted();
    test_latency2();
    test_saturation();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
